// File: rtl/uart_tx_arbiter.sv
// Multi-channel 8N1 UART transmitter: round-robin grants one producer at a time,
// acks it for one cycle and shifts its byte out LSB first, gated by ClearToSend.
`timescale 1ns/1ps

module uart_tx_arbiter #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_CH       = 2
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic [8*NUM_CH-1:0]   Data,
    input  logic [NUM_CH-1:0]     RequestToSend,
    input  logic                  ClearToSend,
    output logic [NUM_CH-1:0]     DataReceivedOut,
    output logic                  SDO,
    output logic                  Busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          idx_q, idx_d;
    logic [7:0]          shift_q, shift_d;
    logic                sdo_q, sdo_d;
    logic                busy_q, busy_d;
    logic [NUM_CH-1:0]   ack_q, ack_d;
    logic [CH_W-1:0]     last_q, last_d;

    logic [7:0]          ch_data [NUM_CH];
    logic                grant_valid;
    logic [CH_W-1:0]     grant_idx;
    logic                bit_done;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign ch_data[i] = Data[8*i +: 8];
    end

    assign bit_done = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // Search downward so the smallest offset from the last grant wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int off = NUM_CH; off >= 1; off--) begin
            if (RequestToSend[CH_W'((int'(last_q) + off) % NUM_CH)]) begin
                grant_valid = 1'b1;
                grant_idx   = CH_W'((int'(last_q) + off) % NUM_CH);
            end
        end
    end

    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        sdo_d   = sdo_q;
        busy_d  = busy_q;
        ack_d   = '0;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                sdo_d  = 1'b1;
                busy_d = 1'b0;
                cnt_d  = '0;
                idx_d  = '0;
                if (ClearToSend && grant_valid) begin
                    state_d          = START;
                    shift_d          = ch_data[grant_idx];
                    ack_d[grant_idx] = 1'b1;
                    last_d           = grant_idx;
                    busy_d           = 1'b1;
                    sdo_d            = 1'b0;
                end
            end

            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    sdo_d   = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                        sdo_d   = 1'b1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        sdo_d   = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others; the async reset clears all of
    // them so an aborted frame can never resume.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            sdo_q   <= 1'b1;
            busy_q  <= 1'b0;
            ack_q   <= '0;
            last_q  <= CH_W'(NUM_CH - 1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            sdo_q   <= sdo_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            last_q  <= last_d;
        end
    end

    assign SDO             = sdo_q;
    assign Busy            = busy_q;
    assign DataReceivedOut = ack_q;

endmodule
